// File: rtl/bp_me_pkg.sv
// Memory-endpoint message types and decode helpers shared by the CCE memory serializer.
// The 512-bit block / 64-bit dword configuration is fixed here for this slice.
package bp_me_pkg;

    localparam int paddr_width_gp        = 40;
    localparam int dword_width_gp        = 64;
    localparam int cce_block_width_gp    = 512;
    localparam int lce_id_width_gp       = 4;
    localparam int lce_assoc_gp          = 8;
    localparam int way_id_width_gp       = $clog2(lce_assoc_gp);
    localparam int beats_gp              = cce_block_width_gp / dword_width_gp;
    localparam int block_offset_width_gp = $clog2(cce_block_width_gp / 8);
    localparam int cnt_width_gp          = $clog2(beats_gp) + 1;
    localparam int mask_width_gp         = dword_width_gp / 8;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011,
        e_cce_mem_wb    = 4'b0100
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_size_e;

    typedef struct packed {
        logic [way_id_width_gp-1:0] way_id;
        logic [lce_id_width_gp-1:0] lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_cmd_type_e       msg_type;
        logic [paddr_width_gp-1:0]  addr;
        bp_mem_size_e               size;
        bp_cce_mem_payload_s        payload;
    } bp_cce_mem_hdr_s;

    typedef struct packed {
        bp_cce_mem_hdr_s                header;
        logic [cce_block_width_gp-1:0]  data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_hdr_width_gp = $bits(bp_cce_mem_hdr_s);
    localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

    typedef enum logic [1:0] {
        e_blk_rd = 2'd0,
        e_blk_wr = 2'd1,
        e_uc_rd  = 2'd2,
        e_uc_wr  = 2'd3
    } bp_cce_mem_class_e;

    // Store misses need fill data, so e_cce_mem_wr is a block read; unknown types fall back to a harmless single read
    function automatic bp_cce_mem_class_e cmd_class(input bp_cce_mem_cmd_type_e msg_type);
        case (msg_type)
            e_cce_mem_rd:    return e_blk_rd;
            e_cce_mem_wr:    return e_blk_rd;
            e_cce_mem_wb:    return e_blk_wr;
            e_cce_mem_uc_rd: return e_uc_rd;
            e_cce_mem_uc_wr: return e_uc_wr;
            default:         return e_uc_rd;
        endcase
    endfunction

    function automatic logic [mask_width_gp-1:0] uc_mask(input bp_mem_size_e size, input logic [2:0] offset);
        logic [mask_width_gp-1:0] base;
        case (size)
            e_mem_size_1: base = 8'h01;
            e_mem_size_2: base = 8'h03;
            e_mem_size_4: base = 8'h0F;
            e_mem_size_8: base = 8'hFF;
            default:      base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic [dword_width_gp-1:0] uc_wdata(input bp_mem_size_e size, input logic [dword_width_gp-1:0] d);
        case (size)
            e_mem_size_1: return {8{d[7:0]}};
            e_mem_size_2: return {4{d[15:0]}};
            e_mem_size_4: return {2{d[31:0]}};
            default:      return d;
        endcase
    endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module bsg_dff_reset_en #(
    parameter int               width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // Capture on enable, otherwise hold
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r <= reset_val_p;
        end else if (en_i) begin
            data_r <= data_i;
        end else begin
            data_r <= data_r;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bp_me_cce_mem_serializer.sv
// Splits one block-wide CCE memory command into dword beats on a narrow memory port and
// reassembles read returns into a single block response carrying the echoed header.
module bp_me_cce_mem_serializer
    import bp_me_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_gp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,

    output logic [cce_mem_msg_width_gp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,

    output logic [paddr_width_gp-1:0]       mem_addr_o,
    output logic                            mem_v_o,
    output logic                            mem_w_o,
    output logic [dword_width_gp-1:0]       mem_data_o,
    output logic [mask_width_gp-1:0]        mem_mask_o,
    input  logic                            mem_ready_i,
    input  logic [dword_width_gp-1:0]       mem_data_i,
    input  logic                            mem_data_v_i
);

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_send  = 2'd1,
        e_recv  = 2'd2,
        e_resp  = 2'd3
    } state_e;

    localparam logic [paddr_width_gp-1:0] dword_bytes_lp = paddr_width_gp'(dword_width_gp / 8);

    state_e                          state_r;
    bp_cce_mem_msg_s                 cmd_s;
    bp_cce_mem_class_e               cls_s;
    logic [cce_mem_hdr_width_gp-1:0] hdr_r;
    logic [cce_block_width_gp-1:0]   cmd_data_r;
    logic [cce_block_width_gp-1:0]   rd_buf_r;
    logic [cnt_width_gp-1:0]         beat_cnt_r;
    logic [cnt_width_gp-1:0]         ret_cnt_r;
    logic [cnt_width_gp-1:0]         beat_nxt_s;
    logic [cnt_width_gp-1:0]         beat_total_s;
    logic [cnt_width_gp-1:0]         ret_cnt_nxt_s;
    logic [beats_gp-1:0]             slot_en_s;
    logic                            is_read_r;
    logic                            is_uc_r;
    logic                            accept_s;
    logic                            beat_fire_s;
    logic                            last_beat_s;
    logic                            capture_s;
    logic                            ret_done_s;
    logic                            cls_uc_s;
    logic                            cls_wr_s;

    assign cmd_s = bp_cce_mem_msg_s'(mem_cmd_i);

    bsg_dff_reset_en #(
        .width_p     (cce_mem_hdr_width_gp),
        .reset_val_p ('0)
    ) hdr_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept_s),
        .data_i  (cmd_s.header),
        .data_o  (hdr_r)
    );

    // Handshake decode and beat/return bookkeeping
    always_comb begin
        cls_s         = cmd_class(cmd_s.header.msg_type);
        cls_uc_s      = (cls_s == e_uc_rd) | (cls_s == e_uc_wr);
        cls_wr_s      = (cls_s == e_blk_wr) | (cls_s == e_uc_wr);
        accept_s      = mem_cmd_ready_o & mem_cmd_v_i;
        beat_fire_s   = mem_v_o & mem_ready_i;
        beat_total_s  = is_uc_r ? cnt_width_gp'(1) : cnt_width_gp'(beats_gp);
        beat_nxt_s    = beat_cnt_r + cnt_width_gp'(1);
        last_beat_s   = beat_fire_s & (beat_nxt_s == beat_total_s);
        // Only returns for beats already issued count; anything else is stray and dropped
        capture_s     = mem_data_v_i & is_read_r
                      & ((state_r == e_send) | (state_r == e_recv))
                      & (ret_cnt_r < beat_cnt_r);
        ret_cnt_nxt_s = ret_cnt_r + cnt_width_gp'(capture_s);
        ret_done_s    = (ret_cnt_nxt_s == beat_total_s);
        for (int i = 0; i < beats_gp; i++) begin
            slot_en_s[i] = capture_s & (ret_cnt_r == cnt_width_gp'(i));
        end
    end

    // Command sequencing, beat issue and registered handshake outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r         <= e_ready;
            beat_cnt_r      <= '0;
            ret_cnt_r       <= '0;
            is_read_r       <= 1'b0;
            is_uc_r         <= 1'b0;
            cmd_data_r      <= '0;
            mem_cmd_ready_o <= 1'b0;
            mem_resp_v_o    <= 1'b0;
            mem_v_o         <= 1'b0;
            mem_w_o         <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            mem_mask_o      <= '0;
        end else begin
            ret_cnt_r <= ret_cnt_nxt_s;
            case (state_r)
                e_ready: begin
                    beat_cnt_r      <= '0;
                    ret_cnt_r       <= '0;
                    mem_cmd_ready_o <= ~accept_s;
                    if (accept_s) begin
                        state_r    <= e_send;
                        cmd_data_r <= cmd_s.data;
                        is_read_r  <= ~cls_wr_s;
                        is_uc_r    <= cls_uc_s;
                        mem_v_o    <= 1'b1;
                        mem_w_o    <= cls_wr_s;
                        if (cls_uc_s) begin
                            mem_addr_o <= {cmd_s.header.addr[paddr_width_gp-1:3], 3'b000};
                            mem_data_o <= uc_wdata(cmd_s.header.size, cmd_s.data[dword_width_gp-1:0]);
                            mem_mask_o <= uc_mask(cmd_s.header.size, cmd_s.header.addr[2:0]);
                        end else begin
                            mem_addr_o <= {cmd_s.header.addr[paddr_width_gp-1:block_offset_width_gp],
                                           {block_offset_width_gp{1'b0}}};
                            mem_data_o <= cmd_s.data[dword_width_gp-1:0];
                            mem_mask_o <= {mask_width_gp{1'b1}};
                        end
                    end
                end
                e_send: begin
                    if (beat_fire_s) begin
                        beat_cnt_r <= beat_nxt_s;
                        if (last_beat_s) begin
                            mem_v_o <= 1'b0;
                            // Fast returns may have completed the block while beats were still issuing
                            if (~is_read_r | ret_done_s) begin
                                state_r      <= e_resp;
                                mem_resp_v_o <= 1'b1;
                            end else begin
                                state_r <= e_recv;
                            end
                        end else begin
                            mem_addr_o <= mem_addr_o + dword_bytes_lp;
                            mem_data_o <= cmd_data_r[int'(beat_nxt_s)*dword_width_gp +: dword_width_gp];
                        end
                    end
                end
                e_recv: begin
                    if (ret_done_s) begin
                        state_r      <= e_resp;
                        mem_resp_v_o <= 1'b1;
                    end
                end
                e_resp: begin
                    if (mem_resp_yumi_i) begin
                        state_r         <= e_ready;
                        mem_resp_v_o    <= 1'b0;
                        mem_cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= e_ready;
                    mem_cmd_ready_o <= 1'b0;
                    mem_resp_v_o    <= 1'b0;
                    mem_v_o         <= 1'b0;
                end
            endcase
        end
    end

    // Read assembly buffer; cleared on accept so uc reads and writes respond zero-filled
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_buf_r <= '0;
        end else if (accept_s) begin
            rd_buf_r <= '0;
        end else begin
            for (int i = 0; i < beats_gp; i++) begin
                if (slot_en_s[i]) begin
                    rd_buf_r[i*dword_width_gp +: dword_width_gp] <= mem_data_i;
                end
            end
        end
    end

    assign mem_resp_o = {hdr_r, rd_buf_r};

endmodule

// File: doc/bp_me_cce_mem_serializer.md
# bp_me_cce_mem_serializer

Memory-side endpoint directly downstream of the uncached engine (UCE). It accepts one `bp_cce_mem_msg_s` command at a time on the mem_cmd channel and breaks block-wide commands into dword beats on a narrow word-addressed memory port. For reads it collects the returned beats into a full block, then returns one `bp_cce_mem_msg_s` response on the mem_resp channel with the command header echoed.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg — processor config; supplies paddr_width_p, dword_width_p, cce_block_width_p, lce_id_width_p.
- lce_assoc_p (from config) — way_id width in the message payload; must match the UCE instance.
- beats_lp (derived) — cce_block_width_p/dword_width_p; 8 for the 512/64 config.

Ports:
- clk_i — input, 1 — single clock.
- reset_i — input, 1 — **asynchronous, active-high** reset.
- mem_cmd_i — input, cce_mem_msg_width_lp — command from the UCE.
- mem_cmd_v_i — input, 1 — command valid.
- mem_cmd_ready_o — output, 1 — command can be accepted.
- mem_resp_o — output, cce_mem_msg_width_lp — response to the UCE.
- mem_resp_v_o — output, 1 — response valid.
- mem_resp_yumi_i — input, 1 — response consumed.
- mem_addr_o — output, paddr_width_p — byte address of the beat, dword aligned.
- mem_v_o — output, 1 — beat request valid.
- mem_w_o — output, 1 — 1 = write, 0 = read.
- mem_data_o — output, dword_width_p — write data.
- mem_mask_o — output, dword_width_p/8 — byte write enables.
- mem_ready_i — input, 1 — memory accepts the beat this cycle.
- mem_data_i — input, dword_width_p — read data.
- mem_data_v_i — input, 1 — read data valid. Returns are in order and cannot be stalled.

## Operation
- States: e_ready, e_send, e_recv, e_resp.
- e_ready:
  - mem_cmd_ready_o = 1.
  - On mem_cmd_v_i, latch the whole message and go to e_send.
  - Clear beat_cnt and ret_cnt.
- Command classes:
  - e_cce_mem_rd and e_cce_mem_wr: block read. A store miss also needs fill data.
  - e_cce_mem_wb: block write.
  - e_cce_mem_uc_rd: single-beat read.
  - e_cce_mem_uc_wr: single-beat write.
- Block operations:
  - Base address is addr with the low log2(cce_block_width_p/8) bits forced to 0.
  - Beat i has address base + 8·i.
  - Beat i carries data[i·64 +: 64].
  - mask = all ones.
  - Number of beats = beats_lp.
- Uncached operations:
  - Address is addr with bits [2:0] cleared.
  - The mask covers 2^size bytes starting at addr[2:0]; size must be ≤ e_mem_size_8.
  - Write data is the low dword of data, replicated across byte lanes so the masked lanes carry it.
- e_send:
  - mem_v_o = 1 with the current beat. The beat advances when mem_v_o & mem_ready_i.
  - After the last beat: writes go to e_resp; reads go to e_recv, or straight to e_resp if all data has already returned.
  - Read beats are issued back-to-back; returns may overlap issue.
- Read data capture:
  - Any mem_data_v_i with ret_cnt < issued beats writes the block buffer slot ret_cnt; ret_cnt then increments.
  - In e_recv, once ret_cnt == beats (1 for uc), go to e_resp.
- e_resp:
  - mem_resp_v_o = 1.
  - mem_resp_o carries the latched msg_type, addr, size and payload (lce_id, way_id) unchanged.
  - data: the assembled block for block reads; {zeros, raw dword} for uc_rd; 0 for writes.
  - On mem_resp_yumi_i, go to e_ready.
- mem_cmd_ready_o is low in every state other than e_ready: one outstanding command.
- mem_data_v_i outside an active read is ignored; a simulation assertion fires on it.

## Timing
- Reset values: mem_cmd_ready_o = 0 while reset_i is high, then 1 in e_ready. mem_resp_v_o = 0, mem_v_o = 0, all counters 0.
- Reset asserted mid-operation: the state machine returns to e_ready immediately, and any in-flight beats and the partial block are discarded.
- Minimum latency, block read with 1-cycle memory return: command accepted at cycle 0; beats issued cycles 1–8; last data at cycle 9; mem_resp_v_o at cycle 10.
- UC write with mem_ready_i high: accept at cycle 0, beat at cycle 1, response at cycle 2.
- mem_resp_o and the mem_* outputs are stable while valid and not yet accepted.
- Back-to-back commands: the next command can be accepted in the cycle after yumi. Ready is a registered-state decode, not combinational on yumi.
- Counter width: log2(beats_lp)+1 bits, no wrap.

## Structure
- The command-class decode function and the uc size-to-mask function go in bp_me_pkg.
- Message structs come from bp_me_pkg through the existing `declare_bp_me_if` macro.
- One sub-module: bsg_dff_reset_en for the latched command header.
- The block buffer is a flat register written by ret_cnt-indexed dword enables.

## Test plan
- e_cce_mem_rd, addr 0x8000_0048, way 2, memory holding pattern addr^0xA5 → 8 read beats at 0x8000_0040..0x8000_0078; response addr 0x8000_0048, way 2, data = the 8 patterns in order.
- e_cce_mem_wb, addr 0x1000, data = dwords 0..7 → 8 writes at 0x1000..0x1038 with mask 0xFF; response data 0.
- e_cce_mem_uc_wr, addr 0x2006, size 2 bytes, data 0xBEEF → one write at 0x2000 with mask 0xC0 and lanes 6–7 = 0xBEEF.
- e_cce_mem_uc_rd, addr 0x3004, memory dword 0x1122334455667788 → response data[63:0] = 0x1122334455667788, upper bits zero.
- mem_ready_i toggled randomly, mem_resp_yumi_i delayed 5 cycles → no beat dropped or duplicated, outputs held stable, mem_cmd_ready_o low throughout.
- reset_i pulsed after 3 read beats → outputs at reset values within the reset cycle; the next rd completes correctly and late mem_data_v_i is ignored.
